ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage of the mini RISC-V pipeline. It owns the program counter, issues word reads to instruction memory through a ready handshake, and absorbs stalls with a one-entry skid register. It applies PC redirects from EX and presents `pc_o`/`inst_o`/`inst_valid_o` to the IF/ID pipeline register, which samples on the following falling edge. `flush_o` drives that register's clear input.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INST`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

- `clk`  in  1: all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `stall_i`  in  1: hazard unit; downstream is not consuming this cycle.
- `redirect_i`  in  1: EX resolved a taken branch or jump.
- `redirect_pc_i`  in  32: target for `redirect_i`.
- `imem_req_o`  out  1: read request.
- `imem_addr_o`  out  32: byte address, word-aligned.
- `imem_rdata_i`  in  32: read data.
- `imem_ready_i`  in  1: `imem_rdata_i` is valid for the current request.
- `pc_o`  out  32: PC of `inst_o`.
- `inst_o`  out  32: fetched instruction, or `NOP_INST` when invalid.
- `inst_valid_o`  out  1: `inst_o` is a real instruction.
- `jal_taken_o`  out  1: `inst_o` is a JAL already followed by fetch.
- `flush_o`  out  1: one-cycle clear to the IF/ID register.
- `misalign_o`  out  1: sticky flag, redirect target had `[1:0]` != 0.

## Operation
- States: `S_RESET`, `S_REQ`, `S_HOLD`.
- Reset values (`rst`=0): state `S_RESET`, `pc`=`RESET_PC`, `pc_o`=`RESET_PC`, `inst_o`=`NOP_INST`, skid empty, and all 1-bit outputs 0.
- `S_RESET`: `imem_req_o`=0. Moves to `S_REQ` on the next cycle.
- `S_REQ`: `imem_req_o`=1 and `imem_addr_o`=`pc`. A response is accepted on the edge where `imem_req_o` and `imem_ready_i` are both 1.
  - Accept with `stall_i`=0: the output register loads {`pc`, `imem_rdata_i`, valid=1}, `pc` takes next_pc, and the state stays `S_REQ`.
  - Accept with `stall_i`=1: the skid register loads the response, the output register holds, and the state moves to `S_HOLD`.
  - No accept with `stall_i`=0: output becomes a bubble (`inst_o`=`NOP_INST`, valid=0, `jal_taken_o`=0).
  - No accept with `stall_i`=1: output holds.
- `S_HOLD`: `imem_req_o`=0. While `stall_i`=1, everything holds. When `stall_i`=0, the skid register moves to the output register, `pc` takes next_pc, and the state moves to `S_REQ`.
- next_pc = `pc`+4, modulo 2^32; 0xFFFF_FFFC wraps to 0.
- Redirect has priority over stall and handshake, and is taken in every state including `S_RESET`:
  - `pc` loads {`redirect_pc_i[31:2]`, 2'b00}.
  - The skid register is emptied and any same-cycle response is discarded.
  - The output register becomes a bubble.
  - `flush_o`=1 for exactly the next cycle.
  - The state moves to `S_REQ`.
- If `redirect_pc_i[1:0]` != 0 during a redirect, `misalign_o` is set. It clears only on reset.
- Reset asserted mid-request drops the outstanding request. Memory must tolerate `imem_req_o` falling without a completed handshake.

## Timing
- Zero-wait memory (`imem_ready_i`=1 whenever requested): one instruction per cycle.
- Latency: the instruction appears on the outputs the cycle after its accepting edge.
- Wait states: each cycle without an accept inserts one bubble, unless `stall_i` holds the outputs.
- First request: the cycle after reset release.
- Redirect: the new address is on `imem_addr_o` the cycle after `redirect_i`, and the first new instruction appears one cycle after that.

## Configuration
- `IFU_JAL_EARLY_EN` defined:
  - When an accepted instruction has opcode 7'b1101111, next_pc = its PC + sign-extended J-immediate.
  - `jal_taken_o`=1 travels with that instruction through the skid and output registers.
  - EX suppresses its redirect for JALs carrying this flag.
- Not defined: next_pc is always `pc`+4 and `jal_taken_o` is tied to 0.

## Structure
- Package `ifu_pkg` holds:
  - the state enum;
  - `OPC_JAL` = 7'b1101111;
  - the default `NOP_INST` and `RESET_PC` constants.
- Sub-module `ifu_jal_target` (combinational J-immediate extract and add) is instantiated only under `IFU_JAL_EARLY_EN`.

## Test plan
- Reset: `rst`=0 for 2 cycles, then 1.
  - During reset: `pc_o`=0, `inst_o`=0x13, valid=0, `imem_req_o`=0.
  - `imem_req_o`=1 with `imem_addr_o`=0x0 the 2nd cycle after release.
- Zero-wait stream, memory returning data = addr:
  - `pc_o`/`inst_o` show 0x0, 0x4, 0x8, 0xC on consecutive cycles with valid=1.
- `stall_i`=1 on the edge accepting 0x8:
  - Outputs hold 0x4 and `imem_req_o`=0.
  - After `stall_i` drops, 0x8 is presented the next cycle and the request for 0xC follows.
- `redirect_i` to 0x100 while waiting on 0x10, with ready arriving the same cycle:
  - The 0x10 data is discarded and `flush_o` pulses once.
  - Next `imem_addr_o`=0x100.
- Redirect to 0x102:
  - `misalign_o`=1, fetch from 0x100.
  - `misalign_o` stays 1 through later redirects until reset.
- JAL at 0x10 with imm=+0x20:
  - Macro defined: next request 0x30 and `jal_taken_o`=1 with the JAL.
  - Macro undefined: next request 0x14 and `jal_taken_o`=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } ifu_state_t;

    localparam logic [6:0]  OPC_JAL      = 7'b1101111;
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory read bus: word request with a ready handshake.
interface ifetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rdata_i,
        input  imem_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rdata_i,
        output imem_ready_i
    );
endinterface

// File: rtl/ifu_jal_target.sv
// Combinational JAL detect and target computation (PC + sign-extended J-immediate).
module ifu_jal_target
    import ifu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:12] i_imm_bits,
    input  logic [6:0]  i_opcode,
    output logic        o_is_jal,
    output logic [31:0] o_target
);
    logic [31:0] w_imm;

    // J-type immediate: imm[20|10:1|11|19:12] lives in inst[31:12]
    assign w_imm = {{11{i_imm_bits[31]}}, i_imm_bits[31], i_imm_bits[19:12],
                    i_imm_bits[20], i_imm_bits[30:21], 1'b0};

    assign o_is_jal = (i_opcode == OPC_JAL);
    assign o_target = i_pc + w_imm;
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem handshake, one-entry skid for stalls,
// redirect handling. Optional macro IFU_JAL_EARLY_EN enables early JAL
// following in fetch.
module ifetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    ifetch_unit_if.master imem,
    output logic [31:0]   pc_o,
    output logic [31:0]   inst_o,
    output logic          inst_valid_o,
    output logic          jal_taken_o,
    output logic          flush_o,
    output logic          misalign_o
);
    ifu_state_t  r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic        r_skid_vld;
    logic [31:0] r_skid_inst;
    logic        r_skid_jal;
    logic [31:0] r_pc_o;
    logic [31:0] r_inst;
    logic        r_vld;
    logic        r_jal;
    logic        r_flush;
    logic        r_misalign;

    logic        w_accept;
    logic [31:0] w_next_pc;
    logic        w_acc_jal;

    assign w_accept = r_req & imem.imem_ready_i;

`ifdef IFU_JAL_EARLY_EN
    // The instruction whose successor is being chosen: skid content when
    // draining from S_HOLD, otherwise the live memory response.
    logic [31:0] w_src_inst;
    logic [31:0] w_jal_tgt;
    logic        w_is_jal;

    assign w_src_inst = (r_state == S_HOLD) ? r_skid_inst : imem.imem_rdata_i;

    ifu_jal_target u_jal_target (
        .i_pc       (r_pc),
        .i_imm_bits (w_src_inst[31:12]),
        .i_opcode   (w_src_inst[6:0]),
        .o_is_jal   (w_is_jal),
        .o_target   (w_jal_tgt)
    );

    assign w_acc_jal = w_is_jal;
    assign w_next_pc = w_is_jal ? w_jal_tgt : r_pc + 32'd4;
`else
    assign w_acc_jal = 1'b0;
    assign w_next_pc = r_pc + 32'd4;
`endif

    // Fetch FSM: PC, skid and output register, all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_RESET;
            r_req       <= 1'b0;
            r_pc        <= RESET_PC;
            r_skid_vld  <= 1'b0;
            r_skid_inst <= NOP_INST;
            r_skid_jal  <= 1'b0;
            r_pc_o      <= RESET_PC;
            r_inst      <= NOP_INST;
            r_vld       <= 1'b0;
            r_jal       <= 1'b0;
            r_flush     <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (redirect_i) begin
                // Redirect wins over stall and handshake; any response this cycle is dropped
                r_pc       <= {redirect_pc_i[31:2], 2'b00};
                r_skid_vld <= 1'b0;
                r_skid_jal <= 1'b0;
                r_inst     <= NOP_INST;
                r_vld      <= 1'b0;
                r_jal      <= 1'b0;
                r_flush    <= 1'b1;
                if (|redirect_pc_i[1:0])
                    r_misalign <= 1'b1;
                r_state    <= S_REQ;
                r_req      <= 1'b1;
            end else begin
                case (r_state)
                    S_RESET: begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                    S_REQ: begin
                        if (w_accept) begin
                            if (!stall_i) begin
                                r_pc_o <= r_pc;
                                r_inst <= imem.imem_rdata_i;
                                r_vld  <= 1'b1;
                                r_jal  <= w_acc_jal;
                                r_pc   <= w_next_pc;
                            end else begin
                                // Park the response; PC advances when it drains
                                r_skid_vld  <= 1'b1;
                                r_skid_inst <= imem.imem_rdata_i;
                                r_skid_jal  <= w_acc_jal;
                                r_state     <= S_HOLD;
                                r_req       <= 1'b0;
                            end
                        end else if (!stall_i) begin
                            r_inst <= NOP_INST;
                            r_vld  <= 1'b0;
                            r_jal  <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (!stall_i) begin
                            r_pc_o     <= r_pc;
                            r_inst     <= r_skid_inst;
                            r_vld      <= r_skid_vld;
                            r_jal      <= r_skid_jal;
                            r_pc       <= w_next_pc;
                            r_skid_vld <= 1'b0;
                            r_state    <= S_REQ;
                            r_req      <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_RESET;
                        r_req   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem.imem_req_o  = r_req;
    assign imem.imem_addr_o = r_pc;
    assign pc_o             = r_pc_o;
    assign inst_o           = r_inst;
    assign inst_valid_o     = r_vld;
    assign jal_taken_o      = r_jal;
    assign flush_o          = r_flush;
    assign misalign_o       = r_misalign;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with hand-computed expectations.
module tb_ifetch_unit;
    localparam logic [31:0] JAL_INST = 32'h0200_006F;  // jal x0, +0x20
`ifdef IFU_JAL_EARLY_EN
    localparam logic [31:0] EXP_AFTER_JAL = 32'h0000_0030;
    localparam logic [31:0] EXP_JAL_FLAG  = 32'd1;
`else
    localparam logic [31:0] EXP_AFTER_JAL = 32'h0000_0014;
    localparam logic [31:0] EXP_JAL_FLAG  = 32'd0;
`endif

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        jal_taken_o;
    logic        flush_o;
    logic        misalign_o;
    logic        mem_ready;
    logic        jal_mode;

    int checks = 0;
    int errors = 0;

    ifetch_unit_if imem ();

    // Memory returns data = address, except a JAL planted at 0x10 when enabled
    assign imem.imem_ready_i = mem_ready;
    assign imem.imem_rdata_i = (jal_mode && imem.imem_addr_o == 32'h10) ? JAL_INST
                                                                        : imem.imem_addr_o;

    ifetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem.master),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .jal_taken_o   (jal_taken_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic vld);
        chk({tag, "_pc"},   pc_o, pc);
        chk({tag, "_inst"}, inst_o, inst);
        chk({tag, "_vld"},  {31'd0, inst_valid_o}, {31'd0, vld});
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        mem_ready = 1'b1; jal_mode = 1'b0;

        // Reset held for two edges
        tick(); tick();
        chk_out("rst", 32'h0, 32'h13, 1'b0);
        chk("rst_req",   {31'd0, imem.imem_req_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_mis",   {31'd0, misalign_o}, 32'd0);
        chk("rst_jal",   {31'd0, jal_taken_o}, 32'd0);

        rst = 1'b1;
        tick();
        chk("first_req",  {31'd0, imem.imem_req_o}, 32'd1);
        chk("first_addr", imem.imem_addr_o, 32'h0);
        chk_out("pre_first", 32'h0, 32'h13, 1'b0);

        // Zero-wait stream
        tick(); chk_out("s0", 32'h0, 32'h0, 1'b1);
        chk("s0_addr", imem.imem_addr_o, 32'h4);
        tick(); chk_out("s4", 32'h4, 32'h4, 1'b1);
        chk("s4_addr", imem.imem_addr_o, 32'h8);

        // Stall on the edge accepting 0x8
        stall_i = 1'b1;
        tick(); chk_out("stall1", 32'h4, 32'h4, 1'b1);
        chk("stall1_req", {31'd0, imem.imem_req_o}, 32'd0);
        tick(); chk_out("stall2", 32'h4, 32'h4, 1'b1);
        chk("stall2_req", {31'd0, imem.imem_req_o}, 32'd0);
        stall_i = 1'b0;
        tick(); chk_out("drain8", 32'h8, 32'h8, 1'b1);
        chk("drain_req",  {31'd0, imem.imem_req_o}, 32'd1);
        chk("drain_addr", imem.imem_addr_o, 32'hC);
        tick(); chk_out("sC", 32'hC, 32'hC, 1'b1);
        chk("sC_addr", imem.imem_addr_o, 32'h10);

        // Wait state on 0x10 inserts a bubble
        mem_ready = 1'b0;
        tick(); chk_out("bubble", 32'hC, 32'h13, 1'b0);
        chk("bubble_addr", imem.imem_addr_o, 32'h10);

        // Redirect to 0x100 with ready arriving the same cycle
        mem_ready = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick(); redirect_i = 1'b0;
        chk_out("redir", 32'hC, 32'h13, 1'b0);
        chk("redir_flush", {31'd0, flush_o}, 32'd1);
        chk("redir_addr",  imem.imem_addr_o, 32'h100);
        tick(); chk_out("r100", 32'h100, 32'h100, 1'b1);
        chk("redir_flush_off", {31'd0, flush_o}, 32'd0);
        chk("r100_mis", {31'd0, misalign_o}, 32'd0);

        // Misaligned redirect
        redirect_i = 1'b1; redirect_pc_i = 32'h102;
        tick(); redirect_i = 1'b0;
        chk("mis_set",  {31'd0, misalign_o}, 32'd1);
        chk("mis_addr", imem.imem_addr_o, 32'h100);
        tick(); chk_out("mis_out", 32'h100, 32'h100, 1'b1);

        // Aligned redirect to a JAL at 0x10
        jal_mode = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h10;
        tick(); redirect_i = 1'b0;
        chk("mis_sticky", {31'd0, misalign_o}, 32'd1);
        chk("jal_addr", imem.imem_addr_o, 32'h10);
        tick(); chk_out("jal_out", 32'h10, JAL_INST, 1'b1);
        chk("jal_flag", {31'd0, jal_taken_o}, EXP_JAL_FLAG);
        chk("jal_next", imem.imem_addr_o, EXP_AFTER_JAL);
        tick(); chk_out("after_jal", EXP_AFTER_JAL, EXP_AFTER_JAL, 1'b1);
        chk("after_jal_flag", {31'd0, jal_taken_o}, 32'd0);

        // PC wrap at top of address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick(); redirect_i = 1'b0;
        chk("wrap_addr0", imem.imem_addr_o, 32'hFFFF_FFFC);
        tick(); chk_out("wrap_out", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_addr1", imem.imem_addr_o, 32'h0);

        // Reset clears the sticky misalign flag and drops the request
        rst = 1'b0;
        tick();
        chk("rst2_mis", {31'd0, misalign_o}, 32'd0);
        chk("rst2_req", {31'd0, imem.imem_req_o}, 32'd0);
        chk_out("rst2", 32'h0, 32'h13, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
